// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared constants for the pipelined carry-lookahead
//                adder/subtractor: operation codes and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Operation select encoding on the 'sub' input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default operand width and lookahead group width
    localparam int CLA_N     = 64;
    localparam int CLA_BLOCK = 16;

endpackage
`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// ============================================================================
//  Module      : cla_block
//  Description : Purely combinational BLOCK-wide carry-lookahead adder group.
//                Every carry is a flat sum-of-products of generate/propagate
//                terms, so no carry ripples bit to bit inside the group.
//                c_msb_in is the carry into the top bit (for overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_block #(
    parameter int BLOCK = 16
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;
    logic             w_pp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        w_c    = '0;
        w_pp   = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            w_c[i+1] = w_g[i];
            w_pp     = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_pp & w_g[j]);
                w_pp     = w_pp & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_pp & cin);
        end
    end

    assign s        = w_p ^ w_c[BLOCK-1:0];
    assign cout     = w_c[BLOCK];
    assign c_msb_in = w_c[BLOCK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_addsub
//  Description : N-bit adder/subtractor split into STAGES = N/BLOCK pipeline
//                stages. Stage k adds group k with one CLA block using the
//                carry registered by stage k-1. Finished sum slices and the
//                not-yet-consumed operand slices travel with the beat.
//                Valid/ready handshake on both sides; whole pipe stalls when
//                the output is held. N must be a multiple of BLOCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int N     = CLA_N,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result,
    output logic         ovf,
    output logic         zero
);

    localparam int STAGES = N / BLOCK;

    // Per-stage pipeline registers
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [STAGES-1:0] r_zero;
    logic [STAGES-1:0] r_ovf;
    logic [STAGES-1:0] r_sub;
    logic [N-1:0]      r_sum [STAGES];
    logic [N-1:0]      r_x   [STAGES];
    logic [N-1:0]      r_y   [STAGES];

    // Next-state values produced by each stage
    logic [STAGES-1:0] w_valid_nx;
    logic [STAGES-1:0] w_carry_nx;
    logic [STAGES-1:0] w_zero_nx;
    logic [STAGES-1:0] w_ovf_nx;
    logic [STAGES-1:0] w_sub_nx;
    logic [N-1:0]      w_sum_nx [STAGES];
    logic [N-1:0]      w_x_nx   [STAGES];
    logic [N-1:0]      w_y_nx   [STAGES];

    logic w_adv;
    logic w_in_fire;

    // The pipe moves whenever the output slot is empty or being drained
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign w_in_fire = in_valid && w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [N-1:0]     w_xin;
        logic [N-1:0]     w_yin;
        logic [N-1:0]     w_sumin;
        logic             w_sub;
        logic             w_cin;
        logic             w_vin;
        logic             w_zin;
        logic [BLOCK-1:0] w_a;
        logic [BLOCK-1:0] w_b;
        logic [BLOCK-1:0] w_s;
        logic             w_cout;
        logic             w_cmsb;

        if (k == 0) begin : g_head
            // First group takes the live operands; carry-in is the sub flag
            assign w_xin   = x;
            assign w_yin   = y;
            assign w_sub   = sub;
            assign w_cin   = sub;
            assign w_vin   = w_in_fire;
            assign w_zin   = 1'b1;
            assign w_sumin = '0;
        end else begin : g_body
            assign w_xin   = r_x[k-1];
            assign w_yin   = r_y[k-1];
            assign w_sub   = r_sub[k-1];
            assign w_cin   = r_carry[k-1];
            assign w_vin   = r_valid[k-1];
            assign w_zin   = r_zero[k-1];
            assign w_sumin = r_sum[k-1];
        end

        assign w_a = w_xin[k*BLOCK +: BLOCK];
        assign w_b = (w_sub == OP_SUB) ? ~w_yin[k*BLOCK +: BLOCK]
                                       :  w_yin[k*BLOCK +: BLOCK];

        cla_block #(
            .BLOCK    (BLOCK)
        ) u_cla (
            .a        (w_a),
            .b        (w_b),
            .cin      (w_cin),
            .s        (w_s),
            .cout     (w_cout),
            .c_msb_in (w_cmsb)
        );

        assign w_valid_nx[k] = w_vin;
        assign w_carry_nx[k] = w_cout;
        assign w_zero_nx[k]  = w_zin & (w_s == '0);
        // Only the last stage's value reaches ovf; it covers bit N-1
        assign w_ovf_nx[k]   = w_cmsb ^ w_cout;
        assign w_sub_nx[k]   = w_sub;
        assign w_x_nx[k]     = w_xin;
        assign w_y_nx[k]     = w_yin;
        assign w_sum_nx[k]   = (w_sumin & ~(N'({BLOCK{1'b1}}) << (k*BLOCK)))
                             | (N'(w_s) << (k*BLOCK));
    end

    // Control and result state: cleared by reset, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_carry <= '0;
            r_zero  <= '0;
            r_ovf   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            r_valid <= w_valid_nx;
            r_carry <= w_carry_nx;
            r_zero  <= w_zero_nx;
            r_ovf   <= w_ovf_nx;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= w_sum_nx[k];
            end
        end
    end

    // Operand skew registers carry only data and are qualified by r_valid
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sub <= w_sub_nx;
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= w_x_nx[k];
                r_y[k] <= w_y_nx[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign result    = {r_carry[STAGES-1], r_sum[STAGES-1]};
    assign ovf       = r_ovf[STAGES-1];
    assign zero      = r_zero[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_cla_addsub
//  Description : Directed self-checking bench for pipelined_cla_addsub
//                (N=64, BLOCK=16, four stages).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_addsub;

    localparam int N = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   result;
    logic         ovf;
    logic         zero;

    int errors = 0;
    int checks = 0;

    pipelined_cla_addsub #(
        .N         (64),
        .BLOCK     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat with out_ready high, wait for its result.
    // lat counts rising edges from the accepting edge to out_valid.
    task automatic run_beat(input logic [N-1:0] ax, input logic [N-1:0] ay,
                            input logic asub, output logic [N:0] res,
                            output logic aovf, output logic az, output int lat);
        out_ready = 1'b1;
        x         = ax;
        y         = ay;
        sub       = asub;
        in_valid  = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        res  = result;
        aovf = ovf;
        az   = zero;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        sub       = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b result=%h ovf=%b zero=%b, need 0/0/0/0",
                     out_valid, result, ovf, zero);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, need 1", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        logic [N:0] r;
        logic       o;
        logic       z;
        int         lat;
        run_beat(64'd3, 64'd3, 1'b0, r, o, z, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency: got %0d, need 4", lat);
        end
        checks++;
        if (r !== 65'd6 || o !== 1'b0 || z !== 1'b0) begin
            errors++;
            $display("FAIL add_3_3: got result=%h ovf=%b zero=%b, need 6/0/0", r, o, z);
        end
        run_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, r, o, z, lat);
        checks++;
        if (r !== {1'b1, 64'd0} || o !== 1'b0 || z !== 1'b1) begin
            errors++;
            $display("FAIL add_ripple: got result=%h ovf=%b zero=%b, need 1_0000000000000000/0/1", r, o, z);
        end
        run_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, r, o, z, lat);
        checks++;
        if (r !== {1'b0, 64'h8000_0000_0000_0000} || o !== 1'b1 || z !== 1'b0) begin
            errors++;
            $display("FAIL add_ovf: got result=%h ovf=%b zero=%b, need 0_8000000000000000/1/0", r, o, z);
        end
        run_beat(64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 1'b0, r, o, z, lat);
        checks++;
        if (r !== {1'b0, 64'h0000_0000_0002_0000} || o !== 1'b0 || z !== 1'b0) begin
            errors++;
            $display("FAIL add_group_carry: got result=%h ovf=%b zero=%b, need 0_0000000000020000/0/0", r, o, z);
        end
    endtask

    task automatic test_sub();
        logic [N:0] r;
        logic       o;
        logic       z;
        int         lat;
        run_beat(64'd1000, 64'd1000, 1'b1, r, o, z, lat);
        checks++;
        if (r !== {1'b1, 64'd0} || o !== 1'b0 || z !== 1'b1) begin
            errors++;
            $display("FAIL sub_equal: got result=%h ovf=%b zero=%b, need 1_0000000000000000/0/1", r, o, z);
        end
        run_beat(64'd0, 64'd1, 1'b1, r, o, z, lat);
        checks++;
        if (r !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF} || o !== 1'b0 || z !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: got result=%h ovf=%b zero=%b, need 0_ffffffffffffffff/0/0", r, o, z);
        end
        run_beat(64'd5, 64'd3, 1'b1, r, o, z, lat);
        checks++;
        if (r !== {1'b1, 64'd2} || o !== 1'b0 || z !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_3: got result=%h ovf=%b zero=%b, need 1_0000000000000002/0/0", r, o, z);
        end
        run_beat(64'h8000_0000_0000_0000, 64'd1, 1'b1, r, o, z, lat);
        checks++;
        if (r !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF} || o !== 1'b1 || z !== 1'b0) begin
            errors++;
            $display("FAIL sub_ovf: got result=%h ovf=%b zero=%b, need 1_7fffffffffffffff/1/0", r, o, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ax [4];
        logic [N-1:0] ay [4];
        logic [N:0]   exp_r [4];
        logic [N:0]   got [$];
        int           idx;
        int           blocked_bad;
        int           blocked_seen;
        ax[0] = 64'd123;    ay[0] = 64'd73;     exp_r[0] = 65'd196;
        ax[1] = 64'd246;    ay[1] = 64'd562;    exp_r[1] = 65'd808;
        ax[2] = 64'd112233; ay[2] = 64'd332211; exp_r[2] = 65'd444444;
        ax[3] = 64'd60;     ay[3] = 64'd50;     exp_r[3] = 65'd110;
        idx          = 0;
        blocked_bad  = 0;
        blocked_seen = 0;
        sub          = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 8);
            in_valid  = (idx < 4);
            x         = (idx < 4) ? ax[idx] : '0;
            y         = (idx < 4) ? ay[idx] : '0;
            #1;
            if (out_valid && !out_ready) begin
                blocked_seen++;
                if (in_ready !== 1'b0) blocked_bad++;
            end
            if (out_valid && out_ready) got.push_back(result);
            @(posedge clk);
            if (in_valid && in_ready) idx++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (blocked_seen !== 4 || blocked_bad !== 0) begin
            errors++;
            $display("FAIL b2b_in_ready: got blocked cycles=%0d with in_ready high=%0d, need 4/0",
                     blocked_seen, blocked_bad);
        end
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, need 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL b2b_result%0d: got none, need %0d", i, exp_r[i]);
            end else if (got[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL b2b_result%0d: got %0d, need %0d", i, got[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b0;
        sub       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x        = 64'd10 + 64'(i);
            y        = 64'd20;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: got out_valid=%b, need 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: got valid=%b result=%h in_ready=%b, need 0/0/1",
                     out_valid, result, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d valid cycles after release, need 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
